// File: rtl/asip_pkg.sv
// Shared ASIP definitions: instruction/PC widths, fetch FSM states and instruction class codes.
// Imported by every ASIP pipeline block.
package asip_pkg;

  localparam int                 INSTR_W   = 32;
  localparam int                 PC_W      = 27;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]         OPC_HALT  = 5'b10111;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    ITYPE_R = 2'b00,
    ITYPE_I = 2'b01,
    ITYPE_J = 2'b10,
    ITYPE_V = 2'b11
  } instr_type_t;

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1:INSTR_W-5];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the 1-cycle synchronous instruction ROM and
// presents one instruction per cycle, handling stalls, squashes, jump redirects and HALT.
module instr_fetch_unit #(
  parameter int                PC_W     = 27,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [4:0]        HALT_OPC = asip_pkg::OPC_HALT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           redirect_en,
  input  logic [PC_W-1:0]                redirect_pc,
  output logic [PC_W-1:0]                imem_addr,
  input  logic [asip_pkg::INSTR_W-1:0]   imem_rdata,
  output logic [asip_pkg::INSTR_W-1:0]   instr,
  output logic                           instr_valid,
  output logic [PC_W-1:0]                instr_pc,
  output logic                           halted
);
  import asip_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc, fetch_d;
  logic [PC_W-1:0] disp_pc, disp_d;
  logic            valid_q, valid_d;
  logic            halt_hit;

  // During a stall the displayed address is re-issued so imem_rdata stays put.
  assign imem_addr   = redirect_en ? redirect_pc : (stall ? disp_pc : fetch_pc);
  assign instr_valid = valid_q && (state_q != HALTED) && !flush && !redirect_en;
  assign instr       = instr_valid ? imem_rdata : NOP_INSTR;
  assign instr_pc    = disp_pc;
  assign halted      = (state_q == HALTED);
  assign halt_hit    = instr_valid && (opcode_of(imem_rdata) == HALT_OPC) && !stall;

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_pc;
    disp_d  = disp_pc;
    valid_d = valid_q;
    if (redirect_en) begin
      disp_d  = redirect_pc;
      fetch_d = redirect_pc + 1'b1;
      valid_d = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        FILL: begin
          disp_d  = fetch_pc;
          fetch_d = fetch_pc + 1'b1;
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (!stall) begin
            if (halt_hit) begin
              state_d = HALTED;
            end else begin
              disp_d  = fetch_pc;
              fetch_d = fetch_pc + 1'b1;
              valid_d = 1'b1;
            end
          end
        end
        HALTED: ;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      fetch_pc <= RESET_PC;
      disp_pc  <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= fetch_d;
      disp_pc  <= disp_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0 and 27'h7FFFFFE), each with a
// 1-cycle synchronous ROM model; inputs change 1ns after the rising edge, checks follow 1ns later.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [26:0] redirect_pc;

  logic [26:0] addr1, pc1, addr2, pc2;
  logic [31:0] rdata1, instr1, rdata2, instr2;
  logic        valid1, halted1, valid2, halted2;

  logic        halt_en;
  int          n_checks;
  int          n_err;

  instr_fetch_unit #(.PC_W(27), .RESET_PC(27'h0), .HALT_OPC(5'b10111)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(addr1), .imem_rdata(rdata1),
    .instr(instr1), .instr_valid(valid1), .instr_pc(pc1), .halted(halted1)
  );

  instr_fetch_unit #(.PC_W(27), .RESET_PC(27'h7FFFFFE), .HALT_OPC(5'b10111)) dut_hi (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(addr2), .imem_rdata(rdata2),
    .instr(instr2), .instr_valid(valid2), .instr_pc(pc2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [26:0] k);
    return {5'b00001, k};
  endfunction

  function automatic logic [31:0] rom(input logic [26:0] a, input logic hen);
    if (hen && a == 27'd4) return {5'b10111, a};
    return word(a);
  endfunction

  always_ff @(posedge clk) begin
    rdata1 <= rom(addr1, halt_en);
    rdata2 <= rom(addr2, 1'b0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out1(input string tag, input logic [31:0] ins, input logic v, input logic [26:0] pc);
    #1;
    chk({tag, ".instr"}, instr1, ins);
    chk({tag, ".valid"}, {31'b0, valid1}, {31'b0, v});
    chk({tag, ".pc"}, {5'b0, pc1}, {5'b0, pc});
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0; halt_en = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // reset release: FILL cycle, then sequential fetch
    #1;
    chk("rst.addr", {5'b0, addr1}, 32'h0);
    chk("rst.valid", {31'b0, valid1}, 32'h0);
    chk("rst.instr", instr1, 32'h0);
    chk("rst.pc", {5'b0, pc1}, 32'h0);
    chk("rst.halted", {31'b0, halted1}, 32'h0);
    tick(); out1("c1", word(0), 1'b1, 27'd0);
    chk("c1.addr", {5'b0, addr1}, 32'd1);
    tick(); out1("c2", word(1), 1'b1, 27'd1);
    tick(); out1("c3", word(2), 1'b1, 27'd2);
    tick(); out1("c4", word(3), 1'b1, 27'd3);
    tick(); tick();

    // stall 3 cycles while pc=5 is shown
    stall = 1'b1;
    out1("st0", word(5), 1'b1, 27'd5);
    chk("st0.addr", {5'b0, addr1}, 32'd5);
    tick(); out1("st1", word(5), 1'b1, 27'd5);
    chk("st1.addr", {5'b0, addr1}, 32'd5);
    tick(); out1("st2", word(5), 1'b1, 27'd5);
    tick(); stall = 1'b0;
    out1("st_rel", word(5), 1'b1, 27'd5);
    chk("st_rel.addr", {5'b0, addr1}, 32'd6);
    tick(); out1("st_next", word(6), 1'b1, 27'd6);
    tick();

    // redirect to 100 while pc=7 shown
    redirect_en = 1'b1; redirect_pc = 27'd100;
    out1("jmp.sq", 32'h0, 1'b0, 27'd7);
    chk("jmp.addr", {5'b0, addr1}, 32'd100);
    tick(); redirect_en = 1'b0;
    out1("jmp.t", word(100), 1'b1, 27'd100);
    tick(); out1("jmp.t1", word(101), 1'b1, 27'd101);

    // redirect during stall
    stall = 1'b1;
    out1("rs.hold", word(101), 1'b1, 27'd101);
    tick(); redirect_en = 1'b1; redirect_pc = 27'd200;
    out1("rs.sq", 32'h0, 1'b0, 27'd101);
    chk("rs.addr", {5'b0, addr1}, 32'd200);
    tick(); redirect_en = 1'b0; stall = 1'b0;
    out1("rs.t", word(200), 1'b1, 27'd200);
    tick(); out1("rs.t1", word(201), 1'b1, 27'd201);

    // HALT at word 4
    halt_en = 1'b1;
    redirect_en = 1'b1; redirect_pc = 27'd2;
    tick(); redirect_en = 1'b0;
    out1("h.pc2", word(2), 1'b1, 27'd2);
    tick(); out1("h.pc3", word(3), 1'b1, 27'd3);
    tick(); out1("h.pc4", {5'b10111, 27'd4}, 1'b1, 27'd4);
    chk("h.pre_halted", {31'b0, halted1}, 32'h0);
    tick(); #1;
    chk("h.halted", {31'b0, halted1}, 32'h1);
    chk("h.valid", {31'b0, valid1}, 32'h0);
    chk("h.instr", instr1, 32'h0);
    tick(); tick(); #1;
    chk("h.stay_halted", {31'b0, halted1}, 32'h1);
    chk("h.stay_valid", {31'b0, valid1}, 32'h0);
    redirect_en = 1'b1; redirect_pc = 27'd0;
    out1("h.jmp_sq", 32'h0, 1'b0, 27'd4);
    tick(); redirect_en = 1'b0; halt_en = 1'b0;
    out1("h.resume", word(0), 1'b1, 27'd0);
    chk("h.resume_halted", {31'b0, halted1}, 32'h0);

    // flush squashes only the current output
    tick(); flush = 1'b1;
    out1("fl.sq", 32'h0, 1'b0, 27'd1);
    tick(); flush = 1'b0;
    out1("fl.next", word(2), 1'b1, 27'd2);

    // RESET_PC near the top of the address space: wrap, then async reset mid-stall
    rst = 1'b0;
    tick(); rst = 1'b1;
    #1;
    chk("hi.rst_addr", {5'b0, addr2}, 32'h7FFFFFE);
    chk("hi.rst_valid", {31'b0, valid2}, 32'h0);
    tick(); #1;
    chk("hi.pc0", {5'b0, pc2}, 32'h7FFFFFE);
    chk("hi.i0", instr2, word(27'h7FFFFFE));
    chk("hi.v0", {31'b0, valid2}, 32'h1);
    tick(); #1;
    chk("hi.pc1", {5'b0, pc2}, 32'h7FFFFFF);
    tick(); #1;
    chk("hi.pc2", {5'b0, pc2}, 32'h0);
    chk("hi.i2", instr2, word(27'h0));
    stall = 1'b1;
    tick(); #1;
    chk("hi.stall_pc", {5'b0, pc2}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ar.instr", instr2, 32'h0);
    chk("ar.valid", {31'b0, valid2}, 32'h0);
    chk("ar.pc", {5'b0, pc2}, 32'h7FFFFFE);
    chk("ar.halted", {31'b0, halted2}, 32'h0);
    chk("ar.addr", {5'b0, addr2}, 32'h7FFFFFE);
    chk("ar.pc_lo", {5'b0, pc1}, 32'h0);
    chk("ar.valid_lo", {31'b0, valid1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
